// File: rtl/addr_decode_prog_if.sv
// Configuration, request and response bus of the programmable address decoder.
// The decoder is the slave; whoever programs rules and issues lookups is the master.
interface addr_decode_prog_if #(
   parameter int unsigned NoIndices = 32'd2,
   parameter int unsigned NoRules   = 32'd4,
   parameter int unsigned AddrWidth = 32'd32
);
   localparam int unsigned IdxWidth = (NoIndices > 32'd1) ? unsigned'($clog2(NoIndices)) : 32'd1;
   localparam int unsigned SelWidth = (NoRules > 32'd1) ? unsigned'($clog2(NoRules)) : 32'd1;

   logic                 cfg_we_i;
   logic [SelWidth-1:0]  cfg_sel_i;
   logic                 cfg_en_i;
   logic [IdxWidth-1:0]  cfg_idx_i;
   logic [AddrWidth-1:0] cfg_start_i;
   logic [AddrWidth-1:0] cfg_end_i;
   logic                 cfg_commit_i;
   logic                 cfg_err_o;

   logic                 req_valid_i;
   logic                 req_ready_o;
   logic [AddrWidth-1:0] req_addr_i;

   logic                 rsp_valid_o;
   logic                 rsp_ready_i;
   logic [IdxWidth-1:0]  rsp_idx_o;
   logic                 rsp_error_o;
   logic [NoRules-1:0]   rsp_hit_o;

   modport master (
      output cfg_we_i, cfg_sel_i, cfg_en_i, cfg_idx_i, cfg_start_i, cfg_end_i, cfg_commit_i,
      output req_valid_i, req_addr_i, rsp_ready_i,
      input  cfg_err_o, req_ready_o, rsp_valid_o, rsp_idx_o, rsp_error_o, rsp_hit_o
   );

   modport slave (
      input  cfg_we_i, cfg_sel_i, cfg_en_i, cfg_idx_i, cfg_start_i, cfg_end_i, cfg_commit_i,
      input  req_valid_i, req_addr_i, rsp_ready_i,
      output cfg_err_o, req_ready_o, rsp_valid_o, rsp_idx_o, rsp_error_o, rsp_hit_o
   );
endinterface

// File: rtl/addr_decode_prog.sv
// Programmable address decoder: shadow/active rule tables with atomic commit,
// range or base/mask matching, highest-slot priority and a registered response.
package cf_math_pkg;
   function automatic int unsigned idx_width(input int unsigned num_idx);
      return (num_idx > 32'd1) ? unsigned'($clog2(num_idx)) : 32'd1;
   endfunction
endpackage

module addr_decode_prog #(
   parameter int unsigned NoIndices = 32'd2,
   parameter int unsigned NoRules   = 32'd4,
   parameter int unsigned AddrWidth = 32'd32,
   parameter bit          Napot     = 1'b0,
   parameter int unsigned CntWidth  = 32'd16,
   localparam int unsigned IdxWidth = cf_math_pkg::idx_width(NoIndices),
   localparam int unsigned SelWidth = cf_math_pkg::idx_width(NoRules)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   addr_decode_prog_if.slave   bus,
   input  logic                en_default_idx_i,
   input  logic [IdxWidth-1:0] default_idx_i,
   output logic [CntWidth-1:0] err_cnt_o
);
   typedef struct packed {
      logic                 en;
      logic [IdxWidth-1:0]  idx;
      logic [AddrWidth-1:0] start_addr;
      logic [AddrWidth-1:0] end_addr;
   } rule_t;

   rule_t shadow_reg  [NoRules];
   rule_t shadow_next [NoRules];
   rule_t active_reg  [NoRules];
   rule_t wr_rule;

   logic sel_bad;
   logic idx_bad;
   logic order_bad;
   logic wr_bad;
   logic wr_ok;

   logic [NoRules-1:0]  match_hit;
   logic                dec_any;
   logic [IdxWidth-1:0] dec_idx;
   logic                dec_error;

   logic                req_ready;
   logic                accept;
   logic                rsp_fire;
   logic                rsp_valid_reg;
   logic [IdxWidth-1:0] rsp_idx_reg;
   logic                rsp_error_reg;
   logic [NoRules-1:0]  rsp_hit_reg;
   logic                cfg_err_reg;
   logic [CntWidth-1:0] err_cnt_reg;

   // Write validation: disabled rules may carry any index or bounds.
   assign sel_bad   = 32'(bus.cfg_sel_i) >= NoRules;
   assign idx_bad   = bus.cfg_en_i && (32'(bus.cfg_idx_i) >= NoIndices);
   assign order_bad = !Napot && bus.cfg_en_i && (bus.cfg_end_i != '0) &&
                      (bus.cfg_start_i >= bus.cfg_end_i);
   assign wr_bad    = sel_bad | idx_bad | order_bad;
   assign wr_ok     = bus.cfg_we_i & ~wr_bad;

   assign wr_rule.en         = bus.cfg_en_i;
   assign wr_rule.idx        = bus.cfg_idx_i;
   assign wr_rule.start_addr = bus.cfg_start_i;
   assign wr_rule.end_addr   = bus.cfg_end_i;

   for (genvar gi = 0; gi < NoRules; gi++) begin : g_slot
      // Commit copies shadow_next so a write landing on the commit edge is included.
      assign shadow_next[gi] = (wr_ok && (bus.cfg_sel_i == SelWidth'(gi))) ? wr_rule : shadow_reg[gi];

      if (Napot) begin : g_napot
         assign match_hit[gi] = active_reg[gi].en &&
            ((bus.req_addr_i & active_reg[gi].end_addr) ==
             (active_reg[gi].start_addr & active_reg[gi].end_addr));
      end else begin : g_range
         assign match_hit[gi] = active_reg[gi].en &&
            (bus.req_addr_i >= active_reg[gi].start_addr) &&
            ((bus.req_addr_i < active_reg[gi].end_addr) || (active_reg[gi].end_addr == '0));
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NoRules; i++) begin
            shadow_reg[i] <= '0;
            active_reg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NoRules; i++) begin
            shadow_reg[i] <= shadow_next[i];
            if (bus.cfg_commit_i) begin
               active_reg[i] <= shadow_next[i];
            end
         end
      end
   end

   // Later slots overwrite earlier ones, so the highest matching slot wins.
   always_comb begin
      dec_any = 1'b0;
      dec_idx = '0;
      for (int i = 0; i < NoRules; i++) begin
         if (match_hit[i]) begin
            dec_any = 1'b1;
            dec_idx = active_reg[i].idx;
         end
      end
      if (!dec_any) begin
         dec_idx = en_default_idx_i ? default_idx_i : '0;
      end
      dec_error = !dec_any && !en_default_idx_i;
   end

   assign req_ready = ~rsp_valid_reg | bus.rsp_ready_i;
   assign accept    = bus.req_valid_i & req_ready;
   assign rsp_fire  = rsp_valid_reg & bus.rsp_ready_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rsp_valid_reg <= 1'b0;
         rsp_idx_reg   <= '0;
         rsp_error_reg <= 1'b0;
         rsp_hit_reg   <= '0;
         cfg_err_reg   <= 1'b0;
         err_cnt_reg   <= '0;
      end else begin
         cfg_err_reg <= bus.cfg_we_i & wr_bad;
         if (accept) begin
            rsp_valid_reg <= 1'b1;
            rsp_idx_reg   <= dec_idx;
            rsp_error_reg <= dec_error;
            rsp_hit_reg   <= match_hit;
         end else if (bus.rsp_ready_i) begin
            rsp_valid_reg <= 1'b0;
         end
         if (rsp_fire && rsp_error_reg && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + CntWidth'(1);
         end
      end
   end

   assign bus.cfg_err_o   = cfg_err_reg;
   assign bus.req_ready_o = req_ready;
   assign bus.rsp_valid_o = rsp_valid_reg;
   assign bus.rsp_idx_o   = rsp_idx_reg;
   assign bus.rsp_error_o = rsp_error_reg;
   assign bus.rsp_hit_o   = rsp_hit_reg;
   assign err_cnt_o       = err_cnt_reg;
endmodule
